muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl_if.sv | 23 ++
 rtl/muldiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// EXE-stage handshake bundle for the multiply/divide controller.
// The master side is the pipeline; the slave side is muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        start_i;
    logic [7:0]  aluop_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        cancel_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, aluop_i, src_a_i, src_b_i, cancel_i,
        input  stall_o, result_valid_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, aluop_i, src_a_i, src_b_i, cancel_i,
        output stall_o, result_valid_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller: 1-cycle multiply, 32-step restoring divide.
// Define DIV_ZERO_BYPASS_EN to short-circuit divide-by-zero straight to DONE.
module muldiv_ctrl (
    input logic          clk,
    input logic          resetn,
    muldiv_ctrl_if.slave bus
);
    localparam logic [7:0] ExeMultOp  = 8'b0001_1000;
    localparam logic [7:0] ExeMultuOp = 8'b0001_1001;
    localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
    localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic        signed_q, signed_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_mul, is_div, is_signed, accept, done_ok;
    logic [31:0] abs_a, div_b_mag, rem_nxt, quo_nxt;
    logic [32:0] shifted, diff;
    logic        step_ok, neg_quo, neg_rem;
    logic [63:0] ext_a, ext_b, product;

    assign is_mul    = (bus.aluop_i == ExeMultOp) || (bus.aluop_i == ExeMultuOp);
    assign is_div    = (bus.aluop_i == ExeDivOp)  || (bus.aluop_i == ExeDivuOp);
    assign is_signed = (bus.aluop_i == ExeMultOp) || (bus.aluop_i == ExeDivOp);
    assign accept    = (state_q == StIdle) && bus.start_i && !bus.cancel_i && (is_mul || is_div);
    assign abs_a     = (is_signed && bus.src_a_i[31]) ? -bus.src_a_i : bus.src_a_i;

    // Low 64 bits of the product are correct for both signednesses after extension.
    assign ext_a   = {{32{signed_q & op_a_q[31]}}, op_a_q};
    assign ext_b   = {{32{signed_q & op_b_q[31]}}, op_b_q};
    assign product = ext_a * ext_b;

    // Divide step: res_hi_q holds the partial remainder, res_lo_q shifts the dividend into quotient.
    assign div_b_mag = (signed_q && op_b_q[31]) ? -op_b_q : op_b_q;
    assign shifted   = {res_hi_q, res_lo_q[31]};
    assign diff      = shifted - {1'b0, div_b_mag};
    assign step_ok   = !diff[32];
    assign rem_nxt   = step_ok ? diff[31:0] : shifted[31:0];
    assign quo_nxt   = {res_lo_q[30:0], step_ok};
    assign neg_quo   = signed_q & (op_a_q[31] ^ op_b_q[31]);
    assign neg_rem   = signed_q & op_a_q[31];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        signed_d = signed_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_a_d   = bus.src_a_i;
                    op_b_d   = bus.src_b_i;
                    signed_d = is_signed;
                    cnt_d    = 5'd0;
                    if (is_mul) begin
                        state_d = StMul;
                    end else begin
                        res_hi_d = 32'd0;
                        res_lo_d = abs_a;
                        state_d  = StDiv;
`ifdef DIV_ZERO_BYPASS_EN
                        if (bus.src_b_i == 32'd0) begin
                            res_hi_d = bus.src_a_i;
                            res_lo_d = 32'hFFFF_FFFF;
                            state_d  = StDone;
                        end
`else
`endif
                    end
                end
            end
            StMul: begin
                if (bus.cancel_i) begin
                    state_d = StIdle;
                end else begin
                    res_hi_d = product[63:32];
                    res_lo_d = product[31:0];
                    state_d  = StDone;
                end
            end
            StDiv: begin
                if (bus.cancel_i) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else if (cnt_q == 5'd31) begin
                    cnt_d    = 5'd0;
                    state_d  = StDone;
                    res_lo_d = neg_quo ? -quo_nxt : quo_nxt;
                    res_hi_d = neg_rem ? -rem_nxt : rem_nxt;
                end else begin
                    cnt_d    = cnt_q + 5'd1;
                    res_hi_d = rem_nxt;
                    res_lo_d = quo_nxt;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!bus.cancel_i) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            signed_q <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            signed_q <= signed_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // The fresh result is visible during DONE; a cancel in DONE keeps the old HI/LO.
    assign done_ok            = (state_q == StDone) && !bus.cancel_i;
    assign bus.result_valid_o = done_ok;
    assign bus.stall_o        = accept || (state_q == StMul) || (state_q == StDiv);
    assign bus.hi_o           = done_ok ? res_hi_q : hi_q;
    assign bus.lo_o           = done_ok ? res_lo_q : lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: latency, results, cancel, DONE-cycle start and reset.
module tb_muldiv_ctrl;
    localparam logic [7:0] OpMult  = 8'b0001_1000;
    localparam logic [7:0] OpMultu = 8'b0001_1001;
    localparam logic [7:0] OpDiv   = 8'b0001_1010;
    localparam logic [7:0] OpDivu  = 8'b0001_1011;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          chk;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;
    bit   last_ok = 1'b1;
    vec_t vecs[10];

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start_i  = 1'b0;
        bus.cancel_i = 1'b0;
        bus.aluop_i  = 8'h00;
        bus.src_a_i  = 32'd0;
        bus.src_b_i  = 32'd0;
    endtask

    // Watch n cycles and flag any result_valid pulse.
    task automatic expect_quiet(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.result_valid_o === 1'b1) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        bit stall_bad;
        @(negedge clk);
        bus.cancel_i = 1'b0;
        bus.start_i  = 1'b1;
        bus.aluop_i  = v.op;
        bus.src_a_i  = v.a;
        bus.src_b_i  = v.b;
        #1;
        check("accept_stall", 64'(bus.stall_o), 64'd1);
        if (last_ok) begin
            check("hold_hi", 64'(bus.hi_o), 64'(last_hi));
            check("hold_lo", 64'(bus.lo_o), 64'(last_lo));
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.src_a_i = $urandom;
        bus.src_b_i = $urandom;
        cyc = 1;
        stall_bad = 1'b0;
        while (bus.result_valid_o !== 1'b1 && cyc < 40) begin
            if (bus.stall_o !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("busy_stall", 64'(stall_bad), 64'd0);
        check("latency", 64'(cyc), 64'(v.lat));
        check("done_stall", 64'(bus.stall_o), 64'd0);
        if (v.chk) begin
            check("res_hi", 64'(bus.hi_o), 64'(v.hi));
            check("res_lo", 64'(bus.lo_o), 64'(v.lo));
            last_hi = v.hi;
            last_lo = v.lo;
            last_ok = 1'b1;
        end else begin
            last_ok = 1'b0;
        end
        @(negedge clk);
        check("valid_pulse", 64'(bus.result_valid_o), 64'd0);
        if (last_ok) check("after_hi", 64'(bus.hi_o), 64'(last_hi));
    endtask

    initial begin
        idle_inputs();
        vecs[0] = '{OpMult,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 2,  1'b1};
        vecs[1] = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2,  1'b1};
        vecs[2] = '{OpDiv,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b1};
        vecs[3] = '{OpDivu,  32'd100,       32'd7,        32'd2,         32'd14,        33, 1'b1};
        vecs[4] = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 1'b1};
        vecs[5] = '{OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 1'b1};
        vecs[6] = '{OpMult,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 2,  1'b1};
        vecs[7] = '{OpMultu, 32'h1234_5678, 32'h10,       32'h1,         32'h2345_6780, 2,  1'b1};
        vecs[8] = '{OpDivu,  32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 33, 1'b1};
`ifdef DIV_ZERO_BYPASS_EN
        vecs[9] = '{OpDivu,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1,  1'b1};
`else
        vecs[9] = '{OpDivu,  32'd5,         32'd0,        32'd0,         32'd0,         33, 1'b0};
`endif

        #2;
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_valid", 64'(bus.result_valid_o), 64'd0);
        check("rst_hi", 64'(bus.hi_o), 64'd0);
        check("rst_lo", 64'(bus.lo_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Non-muldiv opcode and cancel-with-start must both be ignored.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.aluop_i = 8'h20;
        #1;
        check("other_op_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.aluop_i  = OpMult;
        bus.cancel_i = 1'b1;
        #1;
        check("cancel_start_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        idle_inputs();
        expect_quiet("ignored_no_valid", 4);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Cancel a DIVU at cycle 10, then start a new op at cycle 11.
        run_op(vecs[0]);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.aluop_i = OpDivu;
        bus.src_a_i = 32'd100;
        bus.src_b_i = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        bus.cancel_i = 1'b1;
        #1;
        check("cancel_valid", 64'(bus.result_valid_o), 64'd0);
        check("cancel_hi", 64'(bus.hi_o), 64'(last_hi));
        run_op(vecs[7]);

        // Start during DONE is ignored; cancel during DONE suppresses the result.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.aluop_i = OpMultu;
        bus.src_a_i = 32'd2;
        bus.src_b_i = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        check("done2_valid", 64'(bus.result_valid_o), 64'd1);
        check("done2_lo", 64'(bus.lo_o), 64'd6);
        bus.start_i = 1'b1;
        #1;
        check("done_start_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        #1;
        check("post_done_stall", 64'(bus.stall_o), 64'd0);
        expect_quiet("done_start_ignored", 4);
        last_hi = 32'd0;
        last_lo = 32'd6;

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.aluop_i = OpMultu;
        bus.src_a_i = 32'd9;
        bus.src_b_i = 32'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.cancel_i = 1'b1;
        #1;
        check("done_cancel_valid", 64'(bus.result_valid_o), 64'd0);
        check("done_cancel_lo", 64'(bus.lo_o), 64'(last_lo));
        @(negedge clk);
        bus.cancel_i = 1'b0;
        #1;
        check("done_cancel_hold", 64'(bus.lo_o), 64'(last_lo));
        check("done_cancel_idle", 64'(bus.stall_o), 64'd0);

        // Reset at cycle 15 of a DIV.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.aluop_i = OpDiv;
        bus.src_a_i = 32'd1000;
        bus.src_b_i = 32'd3;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_stall", 64'(bus.stall_o), 64'd0);
        check("midrst_valid", 64'(bus.result_valid_o), 64'd0);
        check("midrst_hi", 64'(bus.hi_o), 64'd0);
        check("midrst_lo", 64'(bus.lo_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        expect_quiet("midrst_no_valid", 40);
        last_hi = 32'd0;
        last_lo = 32'd0;
        last_ok = 1'b1;
        run_op(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
